// File: rtl/issue_ctrl.sv
// issue_ctrl: decides each cycle whether the decoded instruction issues into
// the executor or is replaced by a bubble. Stalls on load-use hazards using
// a time-based scoreboard of in-flight load destinations, squashes wrong-path
// instructions after a redirect, and drains/halts on a SYSTEM instruction.
module issue_ctrl #(
    parameter int LOAD_LAT     = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dec_valid,
    input  logic [6:0]  dec_opcode,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic [4:0]  dec_rd,
    output logic        dec_ready,
    output logic        ex_noop,
    input  logic        redirect,
    input  logic        resume,
    output logic        halt,
    output logic [31:0] stall_count
);

    localparam int CW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYCLES);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_DRAIN,
        ST_HALT
    } state_t;

    state_t                     state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [LOAD_LAT-1:0]        sb_valid_q, sb_valid_d;
    logic [LOAD_LAT-1:0][4:0]   sb_rd_q, sb_rd_d;
    logic [31:0]                stall_q, stall_d;

    logic uses_rs1, uses_rs2;
    logic hazard;
    logic sb_empty;
    logic issue;
    logic stall_inc;

    // Which source fields the presented opcode actually reads
    always_comb begin
        uses_rs1 = (dec_opcode == OP_OP)    || (dec_opcode == OP_OPIMM)  ||
                   (dec_opcode == OP_LOAD)  || (dec_opcode == OP_STORE)  ||
                   (dec_opcode == OP_BRANCH)|| (dec_opcode == OP_JALR);
        uses_rs2 = (dec_opcode == OP_OP)    || (dec_opcode == OP_STORE)  ||
                   (dec_opcode == OP_BRANCH);
    end

    // Load-use hazard: a used non-x0 source matches any valid scoreboard rd
    always_comb begin
        hazard = 1'b0;
        for (int unsigned i = 0; i < LOAD_LAT; i++) begin
            if (sb_valid_q[i]) begin
                if (uses_rs1 && (dec_rs1 != 5'd0) && (dec_rs1 == sb_rd_q[i]))
                    hazard = 1'b1;
                if (uses_rs2 && (dec_rs2 != 5'd0) && (dec_rs2 == sb_rd_q[i]))
                    hazard = 1'b1;
            end
        end
        hazard   = hazard & dec_valid;
        sb_empty = ~|sb_valid_q;
    end

    // Next-state and issue decision; reset forces a bubble, redirect overrides state
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dec_ready = 1'b0;
        ex_noop   = 1'b1;
        issue     = 1'b0;
        stall_inc = 1'b0;
        if (!rst) begin
            if (redirect) begin
                dec_ready = 1'b1;
                state_d   = ST_FLUSH;
                cnt_d     = FLUSH_LOAD;
            end else begin
                case (state_q)
                    ST_RUN: begin
                        if (!dec_valid) begin
                            dec_ready = 1'b1;
                        end else if (hazard) begin
                            stall_inc = 1'b1;
                        end else begin
                            issue     = 1'b1;
                            ex_noop   = 1'b0;
                            dec_ready = 1'b1;
                            if (dec_opcode == OP_SYSTEM)
                                state_d = ST_DRAIN;
                        end
                    end
                    ST_FLUSH: begin
                        dec_ready = 1'b1;
                        cnt_d     = cnt_q - CNT_ONE;
                        if (cnt_q <= CNT_ONE)
                            state_d = ST_RUN;
                    end
                    ST_DRAIN: begin
                        if (sb_empty)
                            state_d = ST_HALT;
                    end
                    ST_HALT: begin
                        if (resume)
                            state_d = ST_RUN;
                    end
                    default: state_d = ST_RUN;
                endcase
            end
        end
    end

    // Scoreboard ages every cycle regardless of stalls; only issued loads to rd!=0 insert
    always_comb begin
        sb_valid_d    = '0;
        sb_rd_d       = '0;
        sb_valid_d[0] = issue && (dec_opcode == OP_LOAD) && (dec_rd != 5'd0);
        sb_rd_d[0]    = dec_rd;
        for (int unsigned i = 1; i < LOAD_LAT; i++) begin
            sb_valid_d[i] = sb_valid_q[i-1];
            sb_rd_d[i]    = sb_rd_q[i-1];
        end
        stall_d = (stall_inc && (stall_q != '1)) ? stall_q + 32'd1 : stall_q;
    end

    // State, counter, scoreboard and stall counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            sb_valid_q <= '0;
            sb_rd_q    <= '0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sb_valid_q <= sb_valid_d;
            sb_rd_q    <= sb_rd_d;
            stall_q    <= stall_d;
        end
    end

    assign halt        = (state_q == ST_HALT);
    assign stall_count = stall_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: directed scenarios followed by random
// traffic, all compared against a cycle-numbered behavioural model.
module tb_issue_ctrl;

    localparam int LOAD_LAT     = 2;
    localparam int FLUSH_CYCLES = 2;

    localparam logic [6:0] ADD  = 7'b0110011;
    localparam logic [6:0] ADDI = 7'b0010011;
    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] BEQ  = 7'b1100011;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] SYS  = 7'b1110011;
    localparam logic [6:0] LUI  = 7'b0110111;
    localparam logic [6:0] JAL  = 7'b1101111;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid;
    logic [6:0]  dec_opcode;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic        dec_ready, ex_noop;
    logic        redirect, resume;
    logic        halt;
    logic [31:0] stall_count;

    issue_ctrl #(.LOAD_LAT(LOAD_LAT), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_opcode(dec_opcode),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_ready(dec_ready), .ex_noop(ex_noop),
        .redirect(redirect), .resume(resume),
        .halt(halt), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: cycle number of the latest load issued to each register, the last
    // cycle of the current squash window, and draining/halted flags.
    longint      cyc = 0;
    longint      last_ld [32];
    longint      squash_end;
    bit          draining, halted;
    logic [31:0] stalls;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit reads_rs1(input logic [6:0] op);
        return op inside {ADD, ADDI, LW, SW, BEQ, JALR};
    endfunction

    function automatic bit reads_rs2(input logic [6:0] op);
        return op inside {ADD, SW, BEQ};
    endfunction

    // A register is unavailable in the LOAD_LAT cycles following its load's issue
    function automatic bit busy(input logic [4:0] r);
        longint age;
        age = cyc - last_ld[r];
        return (r != 5'd0) && (age >= 1) && (age <= LOAD_LAT);
    endfunction

    function automatic bit any_busy();
        for (int r = 1; r < 32; r++)
            if (busy(5'(r))) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) last_ld[r] = -1000;
        squash_end = -1;
        draining   = 1'b0;
        halted     = 1'b0;
        stalls     = '0;
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] rd,
                         input logic rdr, input logic rsm);
        dec_valid  = v;
        dec_opcode = op;
        dec_rs1    = r1;
        dec_rs2    = r2;
        dec_rd     = rd;
        redirect   = rdr;
        resume     = rsm;
    endtask

    // One clock: predict, compare mid-cycle, take the edge, advance the model
    task automatic tick();
        bit exp_ready, exp_noop;
        bit do_issue, do_stall, go_halt, go_run;
        bit hz;
        exp_ready = 1'b0; exp_noop = 1'b1;
        do_issue = 1'b0; do_stall = 1'b0; go_halt = 1'b0; go_run = 1'b0;
        #1;
        hz = dec_valid && ((reads_rs1(dec_opcode) && busy(dec_rs1)) ||
                           (reads_rs2(dec_opcode) && busy(dec_rs2)));
        if (rst) begin
            exp_ready = 1'b0;
        end else if (redirect || cyc <= squash_end) begin
            exp_ready = 1'b1;
        end else if (halted) begin
            go_run = resume;
        end else if (draining) begin
            go_halt = !any_busy();
        end else if (!dec_valid) begin
            exp_ready = 1'b1;
        end else if (hz) begin
            do_stall = 1'b1;
        end else begin
            exp_ready = 1'b1;
            exp_noop  = 1'b0;
            do_issue  = 1'b1;
        end
        chk("dec_ready", 32'(dec_ready), 32'(exp_ready));
        chk("ex_noop", 32'(ex_noop), 32'(exp_noop));
        if (!rst) begin
            chk("halt", 32'(halt), 32'(halted));
            chk("stall_count", stall_count, stalls);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else if (redirect) begin
            squash_end = cyc + FLUSH_CYCLES;
            draining   = 1'b0;
            halted     = 1'b0;
        end else begin
            if (go_run) halted = 1'b0;
            if (go_halt) begin draining = 1'b0; halted = 1'b1; end
            if (do_stall && stalls != 32'hFFFF_FFFF) stalls = stalls + 32'd1;
            if (do_issue) begin
                if (dec_opcode == LW && dec_rd != 5'd0) last_ld[dec_rd] = cyc;
                if (dec_opcode == SYS) draining = 1'b1;
            end
        end
        cyc++;
    endtask

    task automatic ins(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd);
        drive(1'b1, op, r1, r2, rd, 1'b0, 1'b0);
        tick();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            drive(1'b0, ADD, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
            tick();
        end
    endtask

    task automatic pulse_redirect();
        drive(1'b1, ADD, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
        tick();
    endtask

    task automatic pulse_resume();
        drive(1'b0, ADD, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        tick();
    endtask

    logic [6:0] ops [9];

    initial begin
        ops = '{ADD, ADDI, LW, SW, BEQ, JALR, SYS, LUI, JAL};
        model_reset();

        // Reset held for two cycles with a valid instruction presented
        rst = 1'b1;
        ins(ADD, 5'd2, 5'd3, 5'd1);
        ins(ADD, 5'd2, 5'd3, 5'd1);
        rst = 1'b0;
        ins(ADD, 5'd2, 5'd3, 5'd1);

        // Load-use: two stalls then issue
        ins(LW, 5'd1, 5'd0, 5'd5);
        repeat (3) ins(ADD, 5'd5, 5'd1, 5'd6);

        // No false hazards: x0 destination, unused rs2 field
        ins(LW, 5'd1, 5'd0, 5'd0);
        ins(ADD, 5'd0, 5'd0, 5'd1);
        ins(LW, 5'd1, 5'd0, 5'd5);
        ins(ADDI, 5'd1, 5'd5, 5'd6);
        idle(2);

        // Store data depends on load
        ins(LW, 5'd1, 5'd0, 5'd5);
        repeat (3) ins(SW, 5'd1, 5'd5, 5'd0);
        idle(3);

        // Single redirect, then back-to-back redirects
        pulse_redirect();
        repeat (4) ins(ADD, 5'd1, 5'd2, 5'd3);
        pulse_redirect();
        pulse_redirect();
        repeat (4) ins(ADD, 5'd1, 5'd2, 5'd3);
        idle(3);

        // SYSTEM with a load in flight, then resume from HALT
        ins(LW, 5'd1, 5'd0, 5'd3);
        ins(SYS, 5'd0, 5'd0, 5'd0);
        idle(4);
        pulse_resume();
        repeat (2) ins(ADD, 5'd1, 5'd2, 5'd3);
        idle(3);

        // Redirect during DRAIN: halt never asserts
        ins(LW, 5'd1, 5'd0, 5'd3);
        ins(SYS, 5'd0, 5'd0, 5'd0);
        pulse_redirect();
        repeat (4) ins(ADD, 5'd1, 5'd2, 5'd3);
        idle(3);

        // Redirect while halted, and resume ignored outside HALT
        ins(SYS, 5'd0, 5'd0, 5'd0);
        pulse_resume();
        idle(3);
        pulse_redirect();
        repeat (4) ins(ADD, 5'd1, 5'd2, 5'd3);

        // Reset mid-DRAIN
        ins(LW, 5'd1, 5'd0, 5'd4);
        ins(SYS, 5'd0, 5'd0, 5'd0);
        rst = 1'b1;
        pulse_redirect();
        rst = 1'b0;
        repeat (2) ins(ADD, 5'd4, 5'd4, 5'd1);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 9) < 8, ops[$urandom_range(0, 8)],
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)),
                  $urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0);
            tick();
        end
        rst = 1'b0;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
